// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared state, opcode, ALU and mux-select encodings for the multi-cycle control unit
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps alu_op/funct3/funct7b5/opcode[5] to alu_control and a funct legality flag
// Optional feature macro: CTRL_XOR_EN (funct3=100 decodes to xor instead of illegal).
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o,
  output logic       legal_o
);

  logic [2:0] funct_ctrl;

  // Legality depends only on funct3 so DECODE can reject before any execute state.
  always_comb begin
    funct_ctrl = ALU_ADD;
    legal_o    = 1'b1;
    case (funct3_i)
      3'b000:  funct_ctrl = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_ctrl = ALU_SLT;
      3'b110:  funct_ctrl = ALU_OR;
      3'b111:  funct_ctrl = ALU_AND;
`ifdef CTRL_XOR_EN
      3'b100:  funct_ctrl = ALU_XOR;
`endif
      default: legal_o = 1'b0;
    endcase
  end

  always_comb begin
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      default:   alu_control_o = funct_ctrl;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle RISC-V control FSM driving datapath selects, enables and alu_control
// Optional feature macro: CTRL_XOR_EN (enables xor/xori via alu_decoder).
module mc_control_unit
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal_instr
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic [2:0] alu_ctrl_raw;
  logic       funct_legal;
  logic       pc_update, branch;
  logic       adr_src_s, mem_write_s, ir_write_s, reg_write_s;
  logic       done_s, illegal_s;
  logic [1:0] result_src_s, src_a_s, src_b_s;

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (opcode[5]),
    .alu_control_o (alu_ctrl_raw),
    .legal_o       (funct_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    alu_op       = ALUOP_ADD;
    pc_update    = 1'b0;
    branch       = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    done_s       = 1'b0;
    illegal_s    = 1'b0;
    result_src_s = RES_ALUOUT;
    src_a_s      = SRCA_PC;
    src_b_s      = SRCB_RS2;
    case (state_q)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        pc_update    = 1'b1;
        src_b_s      = SRCB_FOUR;
        result_src_s = RES_ALURESULT;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        src_a_s = SRCA_OLDPC;
        src_b_s = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = funct_legal ? S_EXECR : S_FETCH;
          OP_I:         state_d = funct_legal ? S_EXECI : S_FETCH;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
        illegal_s = (state_d == S_FETCH);
      end
      S_MEMADR: begin
        src_a_s = SRCA_RS1;
        src_b_s = SRCB_IMM;
        state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_s = RES_MEMDATA;
        reg_write_s  = 1'b1;
        done_s       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        done_s      = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECR: begin
        src_a_s = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a_s = SRCA_RS1;
        src_b_s = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        done_s      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        src_a_s = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        done_s  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        src_a_s   = SRCA_OLDPC;
        src_b_s   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Every output is forced low while reset is held, so an abort never leaks a write.
  assign pc_write      = ~reset & (pc_update | (branch & zero));
  assign adr_src       = ~reset & adr_src_s;
  assign mem_write     = ~reset & mem_write_s;
  assign ir_write      = ~reset & ir_write_s;
  assign reg_write     = ~reset & reg_write_s;
  assign instr_done    = ~reset & done_s;
  assign illegal_instr = ~reset & illegal_s;
  assign result_src    = reset ? 2'b00 : result_src_s;
  assign alu_src_a     = reset ? 2'b00 : src_a_s;
  assign alu_src_b     = reset ? 2'b00 : src_b_s;
  assign alu_control   = reset ? 3'b000 : alu_ctrl_raw;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed self-checking bench for mc_control_unit (expects alu xor only under CTRL_XOR_EN)
module tb_mc_control_unit;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  logic       instr_done, illegal_instr;

  int n_checks = 0;
  int n_pass   = 0;

  mc_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .instr_done    (instr_done),
    .illegal_instr (illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, src_a, src_b, alu_control, instr_done, illegal_instr}
  logic [15:0] obs;
  assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_control, instr_done, illegal_instr};

  function automatic logic [15:0] ev(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] alu, input logic done, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, done, ill};
  endfunction

  task automatic chk(input string tag, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  logic [15:0] e_fetch, e_dec, e_dec_ill, e_memadr, e_memread, e_memwb, e_memwrite, e_aluwb, e_jal;

  initial begin
    e_fetch    = ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    e_dec      = ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0);
    e_dec_ill  = ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 1);
    e_memadr   = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0);
    e_memread  = ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    e_memwb    = ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0);
    e_memwrite = ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
    e_aluwb    = ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
    e_jal      = ev(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0);

    reset = 1'b1;
    zero  = 1'b0;
    set_instr(7'b0000000, 3'b000, 1'b0);
    #1 chk("reset_t0", 16'h0000);
    repeat (3) begin
      step();
      chk("reset_hold", 16'h0000);
    end
    reset = 1'b0;
    #1 chk("fetch_after_reset", e_fetch);

    // R-type sub
    set_instr(7'b0110011, 3'b000, 1'b1);
    step(); chk("sub_decode", e_dec);
    step(); chk("sub_execr", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 0));
    step(); chk("sub_aluwb", e_aluwb);
    step(); chk("sub_fetch", e_fetch);

    // lw
    set_instr(7'b0000011, 3'b010, 1'b0);
    step(); chk("lw_decode", e_dec);
    step(); chk("lw_memadr", e_memadr);
    step(); chk("lw_memread", e_memread);
    step(); chk("lw_memwb", e_memwb);
    step(); chk("lw_fetch", e_fetch);

    // sw, zero held high outside BEQ must have no effect
    set_instr(7'b0100011, 3'b010, 1'b0);
    zero = 1'b1;
    step(); chk("sw_decode", e_dec);
    step(); chk("sw_memadr", e_memadr);
    step(); chk("sw_memwrite", e_memwrite);
    step(); chk("sw_fetch", e_fetch);

    // beq taken then not taken
    set_instr(7'b1100011, 3'b000, 1'b0);
    step(); chk("beq1_decode", e_dec);
    step(); chk("beq_taken", ev(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 1, 0));
    zero = 1'b0;
    step(); chk("beq1_fetch", e_fetch);
    step(); chk("beq2_decode", e_dec);
    step(); chk("beq_not_taken", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 1, 0));
    step(); chk("beq2_fetch", e_fetch);

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    step(); chk("jal_decode", e_dec);
    step(); chk("jal_jal", e_jal);
    step(); chk("jal_aluwb", e_aluwb);
    step(); chk("jal_fetch", e_fetch);

    // slti, and addi with bit30 set (I-type never subtracts)
    set_instr(7'b0010011, 3'b010, 1'b0);
    step(); chk("slti_decode", e_dec);
    step(); chk("slti_execi", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, 0, 0));
    step(); chk("slti_aluwb", e_aluwb);
    step(); chk("slti_fetch", e_fetch);
    set_instr(7'b0010011, 3'b000, 1'b1);
    step(); chk("addi_decode", e_dec);
    step(); chk("addi_execi", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));
    step(); chk("addi_aluwb", e_aluwb);
    step(); chk("addi_fetch", e_fetch);

    // R-type or / and
    set_instr(7'b0110011, 3'b110, 1'b0);
    step(); chk("or_decode", e_dec);
    step(); chk("or_execr", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 0, 0));
    step(); chk("or_aluwb", e_aluwb);
    step(); chk("or_fetch", e_fetch);
    set_instr(7'b0110011, 3'b111, 1'b0);
    step(); chk("and_decode", e_dec);
    step(); chk("and_execr", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 0, 0));
    step(); chk("and_aluwb", e_aluwb);
    step(); chk("and_fetch", e_fetch);

    // illegal opcode: 2 cycles
    set_instr(7'b0000000, 3'b000, 1'b0);
    step(); chk("badop_decode", e_dec_ill);
    step(); chk("badop_fetch", e_fetch);

    // funct3=001 illegal in every build
    set_instr(7'b0110011, 3'b001, 1'b0);
    step(); chk("f3_001_decode", e_dec_ill);
    step(); chk("f3_001_fetch", e_fetch);

    // funct3=100 R-type
    set_instr(7'b0110011, 3'b100, 1'b0);
`ifdef CTRL_XOR_EN
    step(); chk("xor_decode", e_dec);
    step(); chk("xor_execr", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b100, 0, 0));
    step(); chk("xor_aluwb", e_aluwb);
    step(); chk("xor_fetch", e_fetch);
`else
    step(); chk("xor_illegal_decode", e_dec_ill);
    step(); chk("xor_illegal_fetch", e_fetch);
`endif

    // reset during MEMADR of a sw
    set_instr(7'b0100011, 3'b010, 1'b0);
    step(); chk("abort_decode", e_dec);
    step(); chk("abort_memadr", e_memadr);
    #1 reset = 1'b1;
    #1 chk("abort_reset_async", 16'h0000);
    step(); chk("abort_reset_held", 16'h0000);
    reset = 1'b0;
    #1 chk("abort_resume_fetch", e_fetch);
    step(); chk("abort_resume_decode", e_dec);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

- Multi-cycle RISC-V control FSM: the controlling side of the datapath ALU interface.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives `alu_control` with the team's 3-bit ALU encoding, plus datapath mux selects and write enables.
- Consumes the ALU `zero` flag for branch resolution; replaces the single-cycle combinational decoder when the core moves to a shared-memory multi-cycle datapath.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `opcode`  in  7  instruction register bits [6:0]
- `funct3`  in  3  instruction register bits [14:12]
- `funct7b5`  in  1  instruction register bit 30
- `zero`  in  1  ALU zero flag
- `pc_write`  out  1  PC register load enable
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALU out
- `mem_write`  out  1  data memory write enable
- `ir_write`  out  1  instruction register / old-PC load enable
- `reg_write`  out  1  register file write enable
- `result_src`  out  2  00 ALU out reg, 01 mem data reg, 10 ALU result
- `alu_src_a`  out  2  00 PC, 01 old PC, 10 rs1 reg
- `alu_src_b`  out  2  00 rs2 reg, 01 immediate, 10 constant 4
- `alu_control`  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction
- `illegal_instr`  out  1  one-cycle pulse in DECODE on an unsupported encoding

## Operation

- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Outputs are Moore decodes of the state register, with one exception: `pc_write` = pc_update | (branch & `zero`).
- FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, alu add, result_src=10, pc_update=1. Always → DECODE.
- DECODE: src_a=01, src_b=01, alu add (branch target). Next state by opcode:
  - 0000011 lw, 0100011 sw → MEMADR
  - 0110011 R-type → EXECR
  - 0010011 I-type → EXECI
  - 1100011 beq → BEQ
  - 1101111 jal → JAL
  - any other opcode → FETCH with `illegal_instr`=1
- MEMADR: src_a=10, src_b=01, add. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: result_src=00, adr_src=1 → MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done → FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1, instr_done → FETCH.
- EXECR: src_a=10, src_b=00, funct decode → ALUWB.
- EXECI: src_a=10, src_b=01, funct decode → ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done → FETCH.
- BEQ: src_a=10, src_b=00, alu sub, result_src=00, branch=1, instr_done → FETCH.
- JAL: src_a=01, src_b=10, add, result_src=00, pc_update=1 → ALUWB.
- Funct decode:
  - 000: sub if R-type and funct7b5, else add
  - 010 → 101 (slt)
  - 110 → 011 (or)
  - 111 → 010 (and)
  - other funct3 values are illegal: DECODE pulses `illegal_instr` and returns to FETCH; no register write.
- States not listed drive every output to 0, and alu_control=000.

## Timing

- Reset asserted: state=FETCH, but all enables (pc_write, mem_write, ir_write, reg_write) are gated to 0.
- Reset value of every output: all selects 00, alu_control=000, instr_done=0, illegal_instr=0.
- First FETCH enables assert in the first cycle after reset deasserts.
- Cycles per instruction, FETCH to last state inclusive: lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2.
- `zero` is sampled combinationally in BEQ only; `zero` in any other state has no effect.
- Reset mid-instruction: immediate abort to FETCH; no partial memory or register write occurs after assertion.
- Instruction fields must be stable from DECODE until the instruction's final state; `ir_write` is low in those cycles.

## Configuration

- `CTRL_XOR_EN` defined: funct3=100 (xor/xori) decodes to alu_control=100 and executes normally.
- Undefined: funct3=100 is illegal, handled as above.

## Structure

- Shared package `riscv_ctrl_pkg`:
  - state enum
  - opcode constants
  - ALU control constants (ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101)
  - src_a/src_b/result_src select constants
- One sub-module, `alu_decoder`: combinational mapping of alu_op/funct3/funct7b5/opcode[5] to alu_control plus a legal flag. It is instantiated once.

## Test plan

- Reset held 3 cycles, then released: all enables 0 during reset; cycle 1 after release shows ir_write=1, pc_write=1, alu_control=000.
- R-type sub (opcode 0110011, funct3 000, funct7b5=1): alu_control=001 in EXECR; reg_write=1 and instr_done=1 in ALUWB; 4 cycles total.
- lw then sw: lw shows adr_src=1 in MEMREAD and result_src=01 with reg_write=1 in MEMWB (5 cycles); sw shows mem_write=1 in cycle 4.
- beq with zero=1 then zero=0: pc_write=1 in the BEQ cycle only when zero=1; alu_control=001 in both cases.
- Opcode 0000000, then funct3=100 R-type without `CTRL_XOR_EN`: illegal_instr pulses in DECODE, next state FETCH, reg_write never asserts. With the macro defined, the same funct3=100 R-type gives alu_control=100.
- Reset asserted during MEMADR of a sw: mem_write stays 0; FETCH resumes after release.
